// File: rtl/adc_scan_sequencer.sv
// ADC scan sequencer: walks a slot table, issues one ADC command per slot, banks results.
// Optional build macro ADC_SEQ_AVG_EN: four conversions per slot, averaged.
module adc_scan_sequencer #(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = 3,
    parameter int CH_W      = 5,
    parameter int DATA_W    = 12,
    parameter int TIMEOUT   = 1023
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              cfg_wr,
    input  logic [SLOT_W-1:0] cfg_slot,
    input  logic [CH_W-1:0]   cfg_channel,
    input  logic [SLOT_W-1:0] cfg_last_slot,
    input  logic              start,
    input  logic              continuous,
    input  logic              stop,
    output logic              busy,
    output logic              scan_done,
    output logic              cmd_valid,
    output logic [CH_W-1:0]   cmd_channel,
    output logic              cmd_sop,
    output logic              cmd_eop,
    input  logic              cmd_ready,
    input  logic              rsp_valid,
    input  logic [CH_W-1:0]   rsp_channel,
    input  logic [DATA_W-1:0] rsp_data,
    input  logic [SLOT_W-1:0] rd_slot,
    output logic [DATA_W-1:0] rd_data,
    output logic              err_timeout,
    output logic              err_chan,
    input  logic              err_clr
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CH_W-1:0]   r_table  [NUM_SLOTS];
    logic [DATA_W-1:0] r_result [NUM_SLOTS];
    logic [SLOT_W-1:0] r_slot;
    logic [SLOT_W-1:0] r_last;
    logic              r_stop_pend;
    logic [TMO_W-1:0]  r_tmo;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_err_tmo;
    logic              r_err_chan;

    logic [CH_W-1:0]   w_cur_ch;
    logic              w_xfer;
    logic              w_rsp;
    logic              w_tmo_hit;
    logic              w_last;
    logic              w_slot_done;
    logic              w_first_beat;
    logic              w_last_beat;
    logic              w_restart;

    assign w_cur_ch  = r_table[r_slot];
    assign w_xfer    = (r_state == CMD) && cmd_ready;
    assign w_rsp     = (r_state == WAIT) && rsp_valid;
    assign w_tmo_hit = (r_state == WAIT) && !rsp_valid &&
                       (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_last    = (r_slot == r_last);

`ifdef ADC_SEQ_AVG_EN
    logic [1:0]        r_beat;
    logic [DATA_W+1:0] r_sum;
    logic [DATA_W+1:0] w_sum_nx;
    logic              w_beat_done;

    assign w_sum_nx     = r_sum + (DATA_W + 2)'(rsp_data);
    assign w_beat_done  = w_rsp && (r_beat == 2'd3);
    assign w_slot_done  = w_beat_done || w_tmo_hit;
    assign w_first_beat = (r_beat == 2'd0);
    assign w_last_beat  = (r_beat == 2'd3);

    // A timeout throws away the partial sum and restarts the beat count.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_beat <= '0;
            r_sum  <= '0;
        end else if (w_tmo_hit || w_beat_done) begin
            r_beat <= '0;
            r_sum  <= '0;
        end else if (w_rsp) begin
            r_beat <= r_beat + 2'd1;
            r_sum  <= w_sum_nx;
        end
    end
`else
    assign w_slot_done  = w_rsp || w_tmo_hit;
    assign w_first_beat = 1'b1;
    assign w_last_beat  = 1'b1;
`endif

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) r_state <= IDLE;
        else             r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_restart = 1'b0;
        unique case (r_state)
            IDLE: if (start) w_next = CMD;
            CMD:  if (cmd_ready) w_next = WAIT;
            WAIT: begin
                if (w_rsp || w_tmo_hit)
                    w_next = (w_slot_done && w_last) ? DONE : CMD;
            end
            DONE: begin
                if (continuous && !r_stop_pend && !stop) begin
                    w_next    = CMD;
                    w_restart = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_table[i]  <= '0;
                r_result[i] <= '0;
            end
            r_slot      <= '0;
            r_last      <= '0;
            r_stop_pend <= 1'b0;
            r_tmo       <= '0;
            r_rd_data   <= '0;
            r_err_tmo   <= 1'b0;
            r_err_chan  <= 1'b0;
        end else begin
            if (r_state == IDLE && cfg_wr)
                r_table[cfg_slot] <= cfg_channel;

            if ((r_state == IDLE && start) || w_restart) begin
                r_slot <= '0;
                r_last <= cfg_last_slot;
            end else if (w_slot_done && !w_last) begin
                r_slot <= r_slot + 1'b1;
            end

            if (w_xfer)                 r_tmo <= '0;
            else if (r_state == WAIT)   r_tmo <= r_tmo + 1'b1;

            if (r_state == DONE)
                r_stop_pend <= 1'b0;
            else if (stop && r_state != IDLE)
                r_stop_pend <= 1'b1;

`ifdef ADC_SEQ_AVG_EN
            if (w_beat_done) r_result[r_slot] <= w_sum_nx[DATA_W+1:2];
`else
            if (w_rsp) r_result[r_slot] <= rsp_data;
`endif

            // Clear wins over a same-cycle error.
            if (err_clr) begin
                r_err_tmo  <= 1'b0;
                r_err_chan <= 1'b0;
            end else begin
                if (w_tmo_hit) r_err_tmo <= 1'b1;
                if (w_rsp && rsp_channel != w_cur_ch) r_err_chan <= 1'b1;
            end

            r_rd_data <= r_result[rd_slot];
        end
    end

    assign busy        = (r_state != IDLE);
    assign scan_done   = (r_state == DONE);
    assign cmd_valid   = (r_state == CMD);
    assign cmd_channel = (r_state == CMD) ? w_cur_ch : '0;
    assign cmd_sop     = (r_state == CMD) && (r_slot == '0) && w_first_beat;
    assign cmd_eop     = (r_state == CMD) && w_last && w_last_beat;
    assign rd_data     = r_rd_data;
    assign err_timeout = r_err_tmo;
    assign err_chan    = r_err_chan;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer (TIMEOUT overridden to 15).
module tb_adc_scan_sequencer;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic        cfg_wr = 1'b0;
    logic [2:0]  cfg_slot = '0;
    logic [4:0]  cfg_channel = '0;
    logic [2:0]  cfg_last_slot = '0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        stop = 1'b0;
    logic        busy, scan_done, cmd_valid, cmd_sop, cmd_eop;
    logic [4:0]  cmd_channel;
    logic        cmd_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [4:0]  rsp_channel = '0;
    logic [11:0] rsp_data = '0;
    logic [2:0]  rd_slot = '0;
    logic [11:0] rd_data;
    logic        err_timeout, err_chan;
    logic        err_clr = 1'b0;

    int n_pass = 0;
    int n_chk  = 0;
    int n_xfer = 0;
    int x0;

    adc_scan_sequencer #(.TIMEOUT(15)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .cfg_wr(cfg_wr), .cfg_slot(cfg_slot),
        .cfg_channel(cfg_channel), .cfg_last_slot(cfg_last_slot),
        .start(start), .continuous(continuous), .stop(stop),
        .busy(busy), .scan_done(scan_done),
        .cmd_valid(cmd_valid), .cmd_channel(cmd_channel),
        .cmd_sop(cmd_sop), .cmd_eop(cmd_eop), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_channel(rsp_channel),
        .rsp_data(rsp_data), .rd_slot(rd_slot), .rd_data(rd_data),
        .err_timeout(err_timeout), .err_chan(err_chan),
        .err_clr(err_clr)
    );

    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk)
        if (!reset_reset && cmd_valid && cmd_ready) n_xfer++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cfg_write(input logic [2:0] s, input logic [4:0] ch);
        cfg_wr = 1'b1; cfg_slot = s; cfg_channel = ch;
        @(negedge clk_clk);
        cfg_wr = 1'b0;
    endtask

    task automatic start_scan(input logic [2:0] last);
        cfg_last_slot = last;
        start = 1'b1;
        @(negedge clk_clk);
        start = 1'b0;
    endtask

    task automatic wait_cmd(input logic [4:0] ch, input logic sop,
                            input logic eop, input int hold);
        int n = 0;
        logic [7:0] snap;
        while (!cmd_valid && n < 40) begin
            @(negedge clk_clk);
            n++;
        end
        check("cmd_seen", cmd_valid, 1);
        check("cmd_ch", cmd_channel, ch);
        check("cmd_sop", cmd_sop, sop);
        check("cmd_eop", cmd_eop, eop);
        snap = {cmd_valid, cmd_sop, cmd_eop, cmd_channel};
        repeat (hold) begin
            @(negedge clk_clk);
            check("cmd_hold", {cmd_valid, cmd_sop, cmd_eop, cmd_channel}, snap);
        end
        cmd_ready = 1'b1;
        @(negedge clk_clk);
        cmd_ready = 1'b0;
        check("cmd_drop", cmd_valid, 0);
    endtask

    task automatic respond(input int dly, input logic [4:0] ch,
                           input logic [11:0] d);
        repeat (dly) @(negedge clk_clk);
        rsp_valid = 1'b1; rsp_channel = ch; rsp_data = d;
        @(negedge clk_clk);
        rsp_valid = 1'b0;
    endtask

    task automatic read_chk(input logic [2:0] s, input logic [11:0] exp);
        rd_slot = s;
        @(negedge clk_clk);
        check("rd_data", rd_data, exp);
    endtask

    task automatic end_scan();
        check("scan_done", scan_done, 1);
        @(negedge clk_clk);
        check("done_len", scan_done, 0);
        check("busy_idle", busy, 0);
    endtask

`ifdef ADC_SEQ_AVG_EN
    logic [11:0] avg_d [4] = '{12'd10, 12'd11, 12'd12, 12'd14};
`endif

    initial begin
        repeat (2) @(negedge clk_clk);
        check("rst_busy", busy, 0);
        check("rst_valid", cmd_valid, 0);
        check("rst_done", scan_done, 0);
        check("rst_flags", {err_timeout, err_chan, cmd_sop, cmd_eop}, 0);
        check("rst_rd", rd_data, 0);
        reset_reset = 1'b0;
        @(negedge clk_clk);

`ifdef ADC_SEQ_AVG_EN
        cfg_write(3'd0, 5'd3);
        start_scan(3'd0);
        x0 = n_xfer;
        for (int k = 0; k < 4; k++) begin
            wait_cmd(5'd3, k == 0, k == 3, 0);
            respond(1, 5'd3, avg_d[k]);
        end
        end_scan();
        check("avg_xfers", n_xfer - x0, 4);
        read_chk(3'd0, 12'd11);
`else
        cfg_write(3'd0, 5'd3);
        cfg_write(3'd1, 5'd7);
        cfg_write(3'd2, 5'd1);

        // response while idle must be ignored
        rsp_valid = 1'b1; rsp_channel = 5'd9; rsp_data = 12'hFFF;
        @(negedge clk_clk);
        rsp_valid = 1'b0;
        check("idle_rsp_err", err_chan, 0);
        read_chk(3'd0, 12'h000);

        // single scan
        start_scan(3'd2);
        x0 = n_xfer;
        wait_cmd(5'd3, 1, 0, 0);
        respond(1, 5'd3, 12'h100);
        check("no_early_done", scan_done, 0);
        wait_cmd(5'd7, 0, 0, 0);
        respond(1, 5'd7, 12'h200);
        wait_cmd(5'd1, 0, 1, 0);
        respond(1, 5'd1, 12'h300);
        end_scan();
        check("scan1_xfers", n_xfer - x0, 3);
        read_chk(3'd0, 12'h100);
        read_chk(3'd1, 12'h200);
        read_chk(3'd2, 12'h300);

        // backpressure; cfg_wr while busy is dropped
        start_scan(3'd2);
        x0 = n_xfer;
        cfg_write(3'd0, 5'd20);
        wait_cmd(5'd3, 1, 0, 0);
        respond(1, 5'd3, 12'h210);
        wait_cmd(5'd7, 0, 0, 5);
        respond(1, 5'd7, 12'h220);
        wait_cmd(5'd1, 0, 1, 0);
        respond(1, 5'd1, 12'h230);
        end_scan();
        check("bp_xfers", n_xfer - x0, 3);

        // timeout on slot 1
        start_scan(3'd2);
        wait_cmd(5'd3, 1, 0, 0);
        respond(1, 5'd3, 12'h111);
        wait_cmd(5'd7, 0, 0, 0);
        check("tmo_early", err_timeout, 0);
        repeat (14) @(negedge clk_clk);
        check("tmo_w15", {err_timeout, cmd_valid, busy}, 3'b001);
        @(negedge clk_clk);
        check("tmo_set", err_timeout, 1);
        check("tmo_next", {cmd_valid, cmd_channel}, {1'b1, 5'd1});
        wait_cmd(5'd1, 0, 1, 0);
        respond(1, 5'd1, 12'h333);
        end_scan();
        read_chk(3'd1, 12'h220);
        read_chk(3'd2, 12'h333);
        check("tmo_no_chan", err_chan, 0);
        err_clr = 1'b1;
        @(negedge clk_clk);
        err_clr = 1'b0;
        check("tmo_clr", err_timeout, 0);

        // channel mismatch on slot 1
        start_scan(3'd2);
        wait_cmd(5'd3, 1, 0, 0);
        respond(1, 5'd3, 12'h101);
        wait_cmd(5'd7, 0, 0, 0);
        respond(1, 5'd6, 12'hABC);
        check("chan_set", err_chan, 1);
        wait_cmd(5'd1, 0, 1, 0);
        respond(1, 5'd1, 12'h303);
        end_scan();
        read_chk(3'd1, 12'hABC);
        check("chan_no_tmo", err_timeout, 0);
        err_clr = 1'b1;
        @(negedge clk_clk);
        err_clr = 1'b0;
        check("chan_clr", err_chan, 0);

        // continuous, stop during third scan
        continuous = 1'b1;
        start_scan(3'd2);
        x0 = n_xfer;
        for (int s = 0; s < 3; s++) begin
            wait_cmd(5'd3, 1, 0, 0);
            if (s == 2) begin
                stop = 1'b1;
                @(negedge clk_clk);
                stop = 1'b0;
            end
            respond(1, 5'd3, 12'(s));
            wait_cmd(5'd7, 0, 0, 0);
            respond(1, 5'd7, 12'(s + 16));
            wait_cmd(5'd1, 0, 1, 0);
            respond(1, 5'd1, 12'(s + 32));
            check("cont_done", scan_done, 1);
            @(negedge clk_clk);
            check("cont_busy", busy, s < 2);
        end
        repeat (8) @(negedge clk_clk);
        check("cont_xfers", n_xfer - x0, 9);
        check("cont_quiet", {busy, cmd_valid}, 0);
        continuous = 1'b0;
        read_chk(3'd2, 12'd34);

        // reset mid-scan
        start_scan(3'd2);
        check("mid_valid", cmd_valid, 1);
        reset_reset = 1'b1;
        #1;
        check("mid_rst", {busy, cmd_valid}, 0);
        @(negedge clk_clk);
        reset_reset = 1'b0;
        read_chk(3'd1, 12'h000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
